// File: rtl/rvvi_ack_responder.sv
// RVVI trace receive end: reorders packets by minstret, drains them in order and returns ACKs.
// Optional macro RVVI_ACK_DUP_EN: duplicate packets also push an ACK to recover lost ACKs.
module rvvi_ack_responder #(
    parameter int unsigned Entries = 3,
    parameter int unsigned WIDTH   = 792,
    parameter int unsigned WIDTH2  = 96,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RxValid,
    input  logic [WIDTH-1:0]  RxData,
    output logic              RxReady,
    output logic              OutValid,
    output logic [WIDTH-1:0]  OutData,
    input  logic              OutReady,
    output logic              AckValid,
    output logic [WIDTH2-1:0] AckData,
    input  logic              AckReady,
    output logic              HoleTimeout
);

    localparam int unsigned Slots    = 2 ** Entries;
    localparam int unsigned AckDepth = 4;
    localparam int unsigned CntW     = $clog2(TIMEOUT);

    typedef enum logic [0:0] {StRun, StHole} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         hole_cnt_q, hole_cnt_d;
    logic [63:0]             expected_q, expected_d;
    logic [63:0]             last_stored_q, last_stored_d;
    logic [31:0]             stamp_q, stamp_d;
    logic [Slots-1:0]        valid_q, valid_d;
    logic [WIDTH-1:0]        mem_q [Slots];

    logic [WIDTH2-1:0]       ack_mem_q [AckDepth];
    logic [1:0]              ack_wr_q, ack_wr_d;
    logic [1:0]              ack_rd_q, ack_rd_d;
    logic [2:0]              ack_cnt_q, ack_cnt_d;

    logic [63:0]             rx_m;
    logic [63:0]             diff;
    logic [Entries-1:0]      wr_idx;
    logic [Entries-1:0]      rd_idx;
    logic                    rx_fire;
    logic                    in_win;
    logic                    store;
    logic                    dup;
    logic                    rx_push;
    logic                    tmo_push;
    logic                    drain;
    logic                    ack_pop;
    logic [1:0]              tmo_wr_idx;

    // Classification uses Expected as registered, before this cycle's drain.
    always_comb begin
        rx_m    = RxData[63:0];
        diff    = rx_m - expected_q;
        wr_idx  = rx_m[Entries-1:0];
        rd_idx  = expected_q[Entries-1:0];
        RxReady = (ack_cnt_q != 3'(AckDepth));
        rx_fire = RxValid & RxReady;
        in_win  = (diff < 64'(Slots));
        store   = rx_fire & in_win & ~valid_q[wr_idx];
        dup     = rx_fire & ((in_win & valid_q[wr_idx]) | diff[63]);
`ifdef RVVI_ACK_DUP_EN
        rx_push = store | dup;
`else
        rx_push = store;
`endif
        OutValid = valid_q[rd_idx];
        OutData  = mem_q[rd_idx];
        drain    = OutValid & OutReady;
        AckValid = (ack_cnt_q != 3'd0);
        AckData  = ack_mem_q[ack_rd_q];
        ack_pop  = AckValid & AckReady;
    end

    always_comb begin
        state_d    = state_q;
        hole_cnt_d = hole_cnt_q;
        tmo_push   = 1'b0;
        unique case (state_q)
            StRun: begin
                if (!OutValid && (|valid_q)) begin
                    state_d    = StHole;
                    hole_cnt_d = '0;
                end
            end
            StHole: begin
                if (OutValid || !(|valid_q)) begin
                    state_d = StRun;
                end else if (hole_cnt_q == CntW'(TIMEOUT - 1)) begin
                    // A same-cycle packet ACK has priority; otherwise hold the count and retry.
                    if (({1'b0, ack_cnt_q} + {3'b000, rx_push}) < 4'(AckDepth)) begin
                        tmo_push   = 1'b1;
                        hole_cnt_d = '0;
                    end
                end else begin
                    hole_cnt_d = hole_cnt_q + CntW'(1);
                end
            end
            default: state_d = StRun;
        endcase
        HoleTimeout = tmo_push;
    end

    always_comb begin
        stamp_d       = stamp_q + 32'd1;
        expected_d    = expected_q + 64'(drain);
        last_stored_d = store ? rx_m : last_stored_q;
        valid_d       = valid_q;
        if (store) valid_d[wr_idx] = 1'b1;
        if (drain) valid_d[rd_idx] = 1'b0;
        tmo_wr_idx = ack_wr_q + 2'(rx_push);
        ack_wr_d   = ack_wr_q + 2'(rx_push) + 2'(tmo_push);
        ack_rd_d   = ack_rd_q + 2'(ack_pop);
        ack_cnt_d  = ack_cnt_q + 3'(rx_push) + 3'(tmo_push) - 3'(ack_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StRun;
            hole_cnt_q    <= '0;
            expected_q    <= '0;
            last_stored_q <= '0;
            stamp_q       <= '0;
            valid_q       <= '0;
            ack_wr_q      <= '0;
            ack_rd_q      <= '0;
            ack_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            hole_cnt_q    <= hole_cnt_d;
            expected_q    <= expected_d;
            last_stored_q <= last_stored_d;
            stamp_q       <= stamp_d;
            valid_q       <= valid_d;
            ack_wr_q      <= ack_wr_d;
            ack_rd_q      <= ack_rd_d;
            ack_cnt_q     <= ack_cnt_d;
        end
    end

    // Payload storage needs no reset: the valid bits and FIFO count qualify every read.
    always_ff @(posedge clk) begin
        if (store) mem_q[wr_idx] <= RxData;
        if (rx_push) ack_mem_q[ack_wr_q] <= WIDTH2'({stamp_q, rx_m});
        if (tmo_push) ack_mem_q[tmo_wr_idx] <= WIDTH2'({stamp_q, last_stored_q});
    end

endmodule
